reg_file_ctrl: RTL
==================

REG_FILE_CTRL -- requirements
Module: reg_file_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register-file word width.
REQ-002 SHALL have parameter ADDR_W, default 3, register-file address width (8 entries).
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum idle cycles between bytes of one frame.
REQ-004 CLK  in  1  system clock; all logic on its rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 RX_P_DATA  in  8  received command byte, valid when RX_D_VLD=1.
REQ-007 RX_D_VLD  in  1  one-cycle strobe per received byte.
REQ-008 TX_P_DATA  out  8  response byte, stable while TX_D_VLD=1.
REQ-009 TX_D_VLD  out  1  response byte offered.
REQ-010 TX_BUSY  in  1  transmitter cannot accept.
REQ-011 RF_Address  out  ADDR_W  register-file address.
REQ-012 RF_WrData  out  DATA_W  register-file write data.
REQ-013 RF_WrEn  out  1  register-file write strobe.
REQ-014 RF_RdEn  out  1  register-file read enable.
REQ-015 RF_RdData  in  DATA_W  register-file read data, valid one cycle after address is presented with RF_RdEn=1.
REQ-016 CMD_ERR  out  1  one-cycle pulse on any aborted or rejected frame.

Function
REQ-017 Frames SHALL be:
- write: 0xAA, addr, data_hi, data_lo
- read: 0xBB, addr
REQ-018 In IDLE, first bytes other than 0xAA or 0xBB SHALL be dropped and SHALL pulse CMD_ERR.
REQ-019 FSM states SHALL be IDLE, WR_ADDR, WR_DHI, WR_DLO, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_HI, TX_LO.
- Each RX_D_VLD advances exactly one frame-collection state.
REQ-020 An addr byte with bits[7:ADDR_W] nonzero SHALL abort the frame to IDLE with a CMD_ERR pulse and no register-file access.
REQ-021 WR_EXEC SHALL last one cycle and drive RF_WrEn=1, RF_Address=addr, RF_WrData={data_hi,data_lo}.
- That cycle is the cycle after data_lo is accepted.
- The FSM then returns to IDLE.
REQ-022 RD_EXEC SHALL drive RF_Address=addr with RF_RdEn=1.
- RD_WAIT SHALL capture RF_RdData into a DATA_W response buffer on the next edge.
REQ-023 RF_RdEn SHALL equal ~RF_WrEn in every cycle; exactly one strobe is asserted at all times, and idle cycles are non-destructive reads.
REQ-024 RF_Address and RF_WrData SHALL hold their last values outside WR_EXEC/RD_EXEC.
REQ-025 TX handshake: a byte transfers on an edge where TX_D_VLD=1 and TX_BUSY=0.
- TX_HI offers buffer[15:8]; TX_LO offers buffer[7:0]; then the FSM returns to IDLE.
- TX_D_VLD and TX_P_DATA SHALL hold unchanged while TX_BUSY=1, with no upper bound.
REQ-026 Read latency SHALL be: TX_D_VLD asserted 3 cycles after the edge accepting the read addr byte, with TX_BUSY=0.
REQ-027 RX bytes arriving in WR_EXEC, RD_EXEC, RD_WAIT, TX_HI or TX_LO SHALL be dropped with a CMD_ERR pulse; the current operation SHALL continue.
REQ-028 A timeout counter SHALL clear on every accepted byte and increment in WR_ADDR, WR_DHI, WR_DLO and RD_ADDR.
- On reaching TIMEOUT: return to IDLE, pulse CMD_ERR, no register-file access.
- The counter SHALL not run in IDLE or in TX states.
REQ-029 CMD_ERR SHALL never assert for two consecutive cycles from a single event; simultaneous error sources in one cycle SHALL produce one pulse.

Reset
REQ-030 During RST=0, outputs SHALL be:
- state=IDLE, timeout counter=0
- TX_D_VLD=0, TX_P_DATA=0, CMD_ERR=0
- RF_WrEn=0, RF_RdEn=1, RF_Address=0, RF_WrData=0
- response buffer=0
REQ-031 Reset asserted mid-frame or mid-transmit SHALL discard the frame; no partial write and no further TX byte after release.
REQ-032 The first RX_D_VLD on or after the first edge following release SHALL be decoded as a frame start.

Structure
REQ-033 A shared package SHALL hold:
- opcodes CMD_WR=8'hAA, CMD_RD=8'hBB
- the FSM state enumeration
- default DATA_W/ADDR_W/TIMEOUT constants
REQ-034 The timeout counter SHALL be a sub-module frame_timer with inputs clear and run, a TIMEOUT parameter, and a one-cycle expired output.

Verification
REQ-035 RX 0xAA,0x05,0x12,0x34 -> one cycle of RF_WrEn=1, RF_Address=5, RF_WrData=0x1234; RF_RdEn=0 only in that cycle.
REQ-036 Preload addr 5=0x1234, RX 0xBB,0x05, TX_BUSY=0 -> TX bytes 0x12 then 0x34; TX_D_VLD first high 3 cycles after the addr byte.
REQ-037 Same read with TX_BUSY=1 for 20 cycles -> TX_P_DATA=0x12 held stable 20 cycles, then 0x34; RX 0x55 meanwhile -> CMD_ERR pulse, response unaffected.
REQ-038 RX 0xBB,0x09 -> CMD_ERR pulse, no TX_D_VLD; RX 0x77 in IDLE -> CMD_ERR pulse.
REQ-039 With TIMEOUT=10, RX 0xAA,0x03 then silence -> CMD_ERR pulse after 10 cycles, no RF_WrEn; next 0xBB frame decodes normally.
REQ-040 Assert RST after 0xAA,0x02,0x7F -> outputs at reset values; after release RX 0x00 -> CMD_ERR pulse, no write occurs.

Source files
------------

// File: rtl/reg_file_ctrl_pkg.sv
// Shared definitions for the register-file command controller.
//   - command opcodes for the write and read frames
//   - FSM state encoding (also exported on the debug port)
//   - default widths and inter-byte timeout
package reg_file_ctrl_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_TIMEOUT = 1023;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    WR_ADDR = 4'd1,
    WR_DHI  = 4'd2,
    WR_DLO  = 4'd3,
    WR_EXEC = 4'd4,
    RD_ADDR = 4'd5,
    RD_EXEC = 4'd6,
    RD_WAIT = 4'd7,
    TX_HI   = 4'd8,
    TX_LO   = 4'd9
  } state_t;

endpackage

// File: rtl/reg_file_ctrl_frame_timer.sv
// frame_timer: counts idle cycles while a frame is being collected.
// Ports:
//   CLK, RST  clock / asynchronous active-low reset
//   clear     zero the count (takes priority over run)
//   run       count this cycle
//   expired   one-cycle flag: count has reached TIMEOUT while running
// The owner leaves its collecting state when expired is seen, which drops
// run and clears the count, so expired lasts exactly one cycle.
module frame_timer
  import reg_file_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && !clear && (cnt_q == LIMIT);

endmodule

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: decodes byte-serial command frames into register-file
// accesses and returns read data as two response bytes.
//   write frame: 0xAA, addr, data_hi, data_lo
//   read  frame: 0xBB, addr      -> response data_hi, data_lo
// Ports:
//   CLK, RST              clock / asynchronous active-low reset
//   RX_P_DATA, RX_D_VLD   incoming byte and its one-cycle strobe
//   TX_P_DATA, TX_D_VLD   response byte offered; transfers when TX_BUSY=0
//   TX_BUSY               transmitter back-pressure
//   RF_Address/WrData/WrEn/RdEn, RF_RdData   register-file port
//   CMD_ERR               one-cycle pulse on a rejected or aborted frame
//   dbg_state             current FSM state
//
// Handshake: TX byte moves on a rising edge where TX_D_VLD=1 and TX_BUSY=0;
// TX_D_VLD and TX_P_DATA are held unchanged while TX_BUSY=1. The RX side has
// no back-pressure: every RX_D_VLD strobe is consumed in the cycle it occurs.
module reg_file_ctrl
  import reg_file_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_P_DATA,
  input  logic              RX_D_VLD,
  output logic [7:0]        TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              TX_BUSY,
  output logic [ADDR_W-1:0] RF_Address,
  output logic [DATA_W-1:0] RF_WrData,
  output logic              RF_WrEn,
  output logic              RF_RdEn,
  input  logic [DATA_W-1:0] RF_RdData,
  output logic              CMD_ERR,
  output logic [3:0]        dbg_state
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          dhi_q, dhi_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_wrdata_q, rf_wrdata_d;
  logic [DATA_W-1:0]   resp_buf_q, resp_buf_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_vld_q, tx_vld_d;
  logic                cmd_err_q, cmd_err_d;

  logic timer_run;
  logic timer_clear;
  logic timer_expired;
  logic addr_bad;

  // Address bytes must fit the register-file address range.
  assign addr_bad = |(RX_P_DATA >> ADDR_W);

  // Idle time is only measured between bytes of a frame being collected.
  assign timer_run   = (state_q == WR_ADDR) || (state_q == WR_DHI) ||
                       (state_q == WR_DLO)  || (state_q == RD_ADDR);
  assign timer_clear = RX_D_VLD || !timer_run;

  frame_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_frame_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dhi_d       = dhi_q;
    rf_addr_d   = rf_addr_q;
    rf_wrdata_d = rf_wrdata_q;
    resp_buf_d  = resp_buf_q;
    tx_data_d   = tx_data_q;
    tx_vld_d    = tx_vld_q;
    cmd_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR) begin
            state_d = WR_ADDR;
          end else if (RX_P_DATA == CMD_RD) begin
            state_d = RD_ADDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end

      WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_bad) begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            addr_d  = RX_P_DATA[ADDR_W-1:0];
            state_d = WR_DHI;
          end
        end else if (timer_expired) begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
        end
      end

      WR_DHI: begin
        if (RX_D_VLD) begin
          dhi_d   = RX_P_DATA;
          state_d = WR_DLO;
        end else if (timer_expired) begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
        end
      end

      WR_DLO: begin
        if (RX_D_VLD) begin
          // Address and data are loaded here so they are already on the
          // register-file port during the single WR_EXEC cycle.
          rf_addr_d   = addr_q;
          rf_wrdata_d = DATA_W'({dhi_q, RX_P_DATA});
          state_d     = WR_EXEC;
        end else if (timer_expired) begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
        end
      end

      WR_EXEC: begin
        cmd_err_d = RX_D_VLD;
        state_d   = IDLE;
      end

      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_bad) begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            addr_d    = RX_P_DATA[ADDR_W-1:0];
            rf_addr_d = RX_P_DATA[ADDR_W-1:0];
            state_d   = RD_EXEC;
          end
        end else if (timer_expired) begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
        end
      end

      RD_EXEC: begin
        cmd_err_d = RX_D_VLD;
        state_d   = RD_WAIT;
      end

      RD_WAIT: begin
        // Read data is valid now; the high byte is offered straight away.
        cmd_err_d  = RX_D_VLD;
        resp_buf_d = RF_RdData;
        tx_data_d  = 8'(RF_RdData >> (DATA_W - 8));
        tx_vld_d   = 1'b1;
        state_d    = TX_HI;
      end

      TX_HI: begin
        cmd_err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          tx_data_d = 8'(resp_buf_q);
          state_d   = TX_LO;
        end
      end

      TX_LO: begin
        cmd_err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          tx_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      dhi_q       <= '0;
      rf_addr_q   <= '0;
      rf_wrdata_q <= '0;
      resp_buf_q  <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dhi_q       <= dhi_d;
      rf_addr_q   <= rf_addr_d;
      rf_wrdata_q <= rf_wrdata_d;
      resp_buf_q  <= resp_buf_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Exactly one strobe at all times: any non-write cycle is a harmless read.
  assign RF_WrEn    = (state_q == WR_EXEC);
  assign RF_RdEn    = ~RF_WrEn;
  assign RF_Address = rf_addr_q;
  assign RF_WrData  = rf_wrdata_q;
  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign CMD_ERR    = cmd_err_q;
  assign dbg_state  = state_q;

endmodule
